// File: rtl/multicycle_main_fsm_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, opcodes,
// aluOp codes (also used by the ALU decoder) and datapath mux selects.
package multicycle_main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_main_fsm_instr_deco.sv
// Immediate-format decoder: selects the immExt layout from the opcode alone.
module instr_deco
    import multicycle_main_fsm_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] immSrc
);

    always_comb begin
        immSrc = IMM_I;
        case (op)
            OP_SW:   immSrc = IMM_S;
            OP_BEQ:  immSrc = IMM_B;
            OP_JAL:  immSrc = IMM_J;
            default: immSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RISC-V datapath: sequences each instruction
// from FETCH through DECODE and its execute states, driving all datapath controls.
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic               zero,
    output logic               pcWrite,
    output logic               adrSrc,
    output logic               memWrite,
    output logic               irWrite,
    output logic               regWrite,
    output logic [1:0]         resultSrc,
    output logic [1:0]         aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         aluOp,
    output logic [1:0]         immSrc,
    output logic               illegalOp,
    output logic [STATE_W-1:0] state
);

    state_t     state_q, state_d;
    logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_update  = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // oldPC + immExt here is the branch target used later by BEQ.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                if (op == OP_LW)      state_d = S_MEMREAD;
                else if (op == OP_SW) state_d = S_MEMWRITE;
                else                  state_d = S_FETCH;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNC;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNC;
                state_d   = S_ALUWB;
            end
            S_ALUWB: reg_write = 1'b1;
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every control so no write can fire while the state is abandoned.
    assign pcWrite   = ~reset & (pc_update | (branch & zero));
    assign adrSrc    = ~reset & adr_src;
    assign memWrite  = ~reset & mem_write;
    assign irWrite   = ~reset & ir_write;
    assign regWrite  = ~reset & reg_write;
    assign illegalOp = ~reset & illegal;
    assign resultSrc = reset ? 2'b00 : result_src;
    assign aluSrcA   = reset ? 2'b00 : alu_src_a;
    assign aluSrcB   = reset ? 2'b00 : alu_src_b;
    assign aluOp     = reset ? 2'b00 : alu_op;
    assign state     = STATE_W'(state_q);

    instr_deco u_instr_deco (
        .op     (op),
        .immSrc (immSrc)
    );

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: directed and random instruction streams compared
// against a per-opcode state sequence and per-state control table.
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic       zero = 1'b0;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegalOp;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp, immSrc;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    multicycle_main_fsm #(.STATE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .pcWrite   (pcWrite),
        .adrSrc    (adrSrc),
        .memWrite  (memWrite),
        .irWrite   (irWrite),
        .regWrite  (regWrite),
        .resultSrc (resultSrc),
        .aluSrcA   (aluSrcA),
        .aluSrcB   (aluSrcB),
        .aluOp     (aluOp),
        .immSrc    (immSrc),
        .illegalOp (illegalOp),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Observed control word: pcWrite adrSrc memWrite irWrite regWrite resultSrc aluSrcA aluSrcB aluOp illegalOp immSrc
    logic [15:0] obs;
    assign obs = {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc,
                  aluSrcA, aluSrcB, aluOp, illegalOp, immSrc};

    function automatic logic is_legal(input logic [6:0] o);
        return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
               (o == 7'b0010011) || (o == 7'b1101111) || (o == 7'b1100011);
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Instruction walk from FETCH back to (excluding) the next FETCH.
    function automatic void push_seq(input logic [6:0] o);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        case (o)
            7'b0000011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
            7'b0100011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
            7'b0110011: begin exp_q.push_back(4'd6); exp_q.push_back(4'd7); end
            7'b0010011: begin exp_q.push_back(4'd8); exp_q.push_back(4'd7); end
            7'b1101111: begin exp_q.push_back(4'd9); exp_q.push_back(4'd7); end
            7'b1100011: exp_q.push_back(4'd10);
            default: ;
        endcase
    endfunction

    function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic [6:0] o, input logic z);
        logic pcu, br, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, ao;
        {pcu, br, adr, mw, irw, rw, ill} = 7'b0;
        {rs, sa, sb, ao} = 8'b0;
        case (st)
            4'd0:  begin irw = 1; sb = 2'b10; rs = 2'b10; pcu = 1; end
            4'd1:  begin sa = 2'b01; sb = 2'b01; ill = !is_legal(o); end
            4'd2:  begin sa = 2'b10; sb = 2'b01; end
            4'd3:  adr = 1;
            4'd4:  begin rs = 2'b01; rw = 1; end
            4'd5:  begin adr = 1; mw = 1; end
            4'd6:  begin sa = 2'b10; ao = 2'b10; end
            4'd7:  rw = 1;
            4'd8:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            4'd9:  begin sa = 2'b01; sb = 2'b10; pcu = 1; end
            4'd10: begin sa = 2'b10; ao = 2'b01; br = 1; end
            default: ;
        endcase
        return {pcu | (br & z), adr, mw, irw, rw, rs, sa, sb, ao, ill, exp_imm(o)};
    endfunction

    // Entry: shortly after a rising edge with the DUT in FETCH. Exit: same point, back in FETCH.
    task automatic run_instr(input logic [6:0] o, input string name);
        logic [3:0]  exp_st;
        logic [15:0] exp_v;
        op = o;
        push_seq(o);
        while (exp_q.size() > 0) begin
            exp_st = exp_q.pop_front();
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_v = exp_outs(exp_st, o, zero);
            checks++;
            if (state !== exp_st) begin
                errors++;
                $display("FAIL %s state: got %0d expected %0d (op=%b)", name, state, exp_st, o);
            end
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s outputs in state %0d: got %b expected %b (op=%b zero=%b)",
                         name, exp_st, obs, exp_v, o, zero);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL %s return to FETCH: got %0d expected 0", name, state);
        end
    endtask

    task automatic check_reset_outs(input string name);
        checks++;
        if (state !== 4'd0 || obs !== {14'b0, exp_imm(op)}) begin
            errors++;
            $display("FAIL %s: got state=%0d outs=%b expected state=0 outs=%b",
                     name, state, obs, {14'b0, exp_imm(op)});
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(7'b0110011, "pre_reset_r");
        @(posedge clk); #1;   // now in DECODE
        #3 reset = 1'b1;      // mid-cycle assertion
        #1 check_reset_outs("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outs("reset_hold");
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || irWrite !== 1'b1 || pcWrite !== 1'b1 || aluSrcB !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got state=%0d irWrite=%b pcWrite=%b aluSrcB=%b expected 0 1 1 10",
                     state, irWrite, pcWrite, aluSrcB);
        end
    endtask

    task automatic test_lw();   run_instr(7'b0000011, "lw");   endtask
    task automatic test_sw();   run_instr(7'b0100011, "sw");   endtask
    task automatic test_rtype(); run_instr(7'b0110011, "rtype"); run_instr(7'b0010011, "itype"); endtask
    task automatic test_jal();  run_instr(7'b1101111, "jal");  endtask
    task automatic test_illegal(); run_instr(7'b1111111, "illegal"); run_instr(7'b0000000, "illegal0"); endtask

    task automatic test_beq();
        for (int i = 0; i < 6; i++) run_instr(7'b1100011, "beq");
    endtask

    task automatic test_reset_mid();
        op = 7'b0100011;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (state !== 4'd5 || memWrite !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_memwrite: got state=%0d memWrite=%b expected 5 1", state, memWrite);
        end
        #2 reset = 1'b1;
        #1 check_reset_outs("mid_reset_async");
        @(negedge clk);
        check_reset_outs("mid_reset_hold");
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(7'b0000011, "after_mid_reset");
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[6];
        logic [6:0] o;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) o = 7'($urandom_range(0, 127));
            else o = ops[$urandom_range(0, 5)];
            run_instr(o, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        run_instr(7'b0000011, "lw_after_release_tail_check");
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
